// File: rtl/inst_sram_responder_pkg.sv
// Shared constants and elaboration-time helpers for the instruction-side
// SRAM responder.
//   INST_SRAM_ADDR_W / INST_SRAM_DATA_W : bus widths, also used by the IF stage
//   ptr_width  : width of a circular-queue pointer for a given depth
//   wait_width : width of a per-entry wait counter for a given latency
//   wait_init  : load value of the wait counter when a request is accepted
package inst_sram_responder_pkg;

    localparam int INST_SRAM_ADDR_W = 32'sd32;
    localparam int INST_SRAM_DATA_W = 32'sd32;

    function automatic int ptr_width(input int depth);
        if (depth > 32'sd1) begin
            return $clog2(depth);
        end else begin
            return 32'sd1;
        end
    endfunction

    function automatic int wait_width(input int latency);
        return $clog2(latency) + 32'sd1;
    endfunction

    // The first cycle after acceptance already counts toward the latency,
    // so the counter is loaded with LATENCY-1 and saturates at zero.
    function automatic int wait_init(input int latency);
        if (latency > 32'sd1) begin
            return latency - 32'sd1;
        end else begin
            return 32'sd0;
        end
    endfunction

endpackage

// File: rtl/inst_sram_responder_chk.sv
// Protocol checker for the responder's return side (simulation only).
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   data_ok     return strobe
//   rdata       return data
//   cnt         queue occupancy
module inst_sram_responder_chk
    import inst_sram_responder_pkg::*;
#(
    parameter int CW     = 2,
    parameter int MAXCNT = 2
) (
    input logic                        clk,
    input logic                        reset,
    input logic                        data_ok,
    input logic [INST_SRAM_DATA_W-1:0] rdata,
    input logic [CW-1:0]               cnt
);

    a_no_return_when_empty: assert property (
        @(posedge clk) disable iff (reset) data_ok |-> (cnt != {CW{1'b0}}));

    a_cnt_bounded: assert property (
        @(posedge clk) disable iff (reset) cnt <= CW'(MAXCNT));

    a_rdata_known: assert property (
        @(posedge clk) disable iff (reset) data_ok |-> !$isunknown(rdata));

endmodule

// File: rtl/inst_sram_responder_resp_fifo.sv
// In-order response queue of DEPTH entries.
// Each entry carries the read word, a flag telling whether the word has been
// captured from the RAM yet, and an independent wait counter.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   push, pop     enqueue at tail / dequeue head (both allowed in one cycle)
//   cap_data      RAM read data; captured into the entry pushed last cycle
//   full, empty   occupancy flags
//   cnt           current occupancy (0..DEPTH)
//   head_ready    head present and its wait counter has reached zero
//   head_dvalid   head word already captured
//   head_data     captured head word
module resp_fifo
    import inst_sram_responder_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int LATENCY = 3,
    parameter int WW      = 3,
    parameter int CW      = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [INST_SRAM_DATA_W-1:0] cap_data,
    output logic                        full,
    output logic                        empty,
    output logic [CW-1:0]               cnt,
    output logic                        head_ready,
    output logic                        head_dvalid,
    output logic [INST_SRAM_DATA_W-1:0] head_data
);

    localparam int              PW        = ptr_width(DEPTH);
    localparam logic [WW-1:0]   WAIT_INIT = WW'(wait_init(LATENCY));
    localparam logic [PW-1:0]   PTR_LAST  = PW'(DEPTH - 32'sd1);
    localparam logic [CW-1:0]   CNT_FULL  = CW'(DEPTH);

    logic [INST_SRAM_DATA_W-1:0] data_r   [DEPTH];
    logic [WW-1:0]               wait_r   [DEPTH];
    logic [DEPTH-1:0]            dvalid_r;
    logic [PW-1:0]               head_r;
    logic [PW-1:0]               tail_r;
    logic [PW-1:0]               cap_idx_r;
    logic                        cap_pend_r;
    logic [CW-1:0]               cnt_r;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PTR_LAST) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1'b1);
        end
    endfunction

    // Head/tail pointers, occupancy and the pending-capture marker
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
            cap_idx_r  <= {PW{1'b0}};
            cap_pend_r <= 1'b0;
            cnt_r      <= {CW{1'b0}};
        end else begin
            cap_pend_r <= push;
            cap_idx_r  <= tail_r;
            if (push) begin
                tail_r <= ptr_inc(tail_r);
            end
            if (pop) begin
                head_r <= ptr_inc(head_r);
            end
            case ({push, pop})
                2'b10:   cnt_r <= cnt_r + CW'(1'b1);
                2'b01:   cnt_r <= cnt_r - CW'(1'b1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Per-entry payload, capture flag and wait counter; a new push into a slot
    // wins over a stale capture aimed at the same slot
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i]   <= {INST_SRAM_DATA_W{1'b0}};
                wait_r[i]   <= {WW{1'b0}};
                dvalid_r[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (tail_r == PW'(i))) begin
                    wait_r[i]   <= WAIT_INIT;
                    dvalid_r[i] <= 1'b0;
                end else begin
                    if (wait_r[i] != {WW{1'b0}}) begin
                        wait_r[i] <= wait_r[i] - WW'(1'b1);
                    end
                    if (cap_pend_r && (cap_idx_r == PW'(i))) begin
                        data_r[i]   <= cap_data;
                        dvalid_r[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Status decode of the head entry
    always_comb begin
        empty       = (cnt_r == {CW{1'b0}});
        full        = (cnt_r == CNT_FULL);
        cnt         = cnt_r;
        head_ready  = 1'b0;
        head_dvalid = dvalid_r[head_r];
        head_data   = data_r[head_r];
        if (!empty && (wait_r[head_r] == {WW{1'b0}})) begin
            head_ready = 1'b1;
        end else begin
            head_ready = 1'b0;
        end
    end

endmodule

// File: rtl/inst_sram_responder.sv
// Slave end of the sram-like instruction fetch interface.
// Accepts up to OUTSTANDING reads, issues each to a 1-cycle synchronous RAM in
// its accept cycle and returns the words in order, no earlier than LATENCY
// cycles after acceptance.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   inst_sram_req       read request valid
//   inst_sram_addr      byte address, bits [1:0] ignored
//   inst_sram_addr_ok   request accepted this cycle
//   inst_sram_data_ok   inst_sram_rdata valid this cycle (no back-pressure)
//   inst_sram_rdata     read data, zero when data_ok is low
//   addr_hold           forces addr_ok low to model a bus stall
//   ram_en, ram_addr    backing RAM read port (word address)
//   ram_rdata           backing RAM data, valid one cycle after ram_en
module inst_sram_responder
    import inst_sram_responder_pkg::*;
#(
    parameter int LATENCY     = 3,
    parameter int OUTSTANDING = 2,
    parameter int AW          = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        inst_sram_req,
    input  logic [INST_SRAM_ADDR_W-1:0] inst_sram_addr,
    output logic                        inst_sram_addr_ok,
    output logic                        inst_sram_data_ok,
    output logic [INST_SRAM_DATA_W-1:0] inst_sram_rdata,
    input  logic                        addr_hold,
    output logic                        ram_en,
    output logic [AW-1:0]               ram_addr,
    input  logic [INST_SRAM_DATA_W-1:0] ram_rdata
);

    localparam int WW = wait_width(LATENCY);
    localparam int CW = $clog2(OUTSTANDING + 32'sd1);

    logic                        addr_ok_s;
    logic                        data_ok_s;
    logic [INST_SRAM_DATA_W-1:0] rdata_s;
    logic [AW-1:0]               ram_addr_s;
    logic                        full_s;
    logic                        empty_s;
    logic [CW-1:0]               cnt_s;
    logic                        head_ready_s;
    logic                        head_dvalid_s;
    logic [INST_SRAM_DATA_W-1:0] head_data_s;
    logic                        unused_addr_s;

    // Byte-offset and upper address bits alias onto the same RAM words
    assign unused_addr_s = ^inst_sram_addr;

    resp_fifo #(
        .DEPTH   (OUTSTANDING),
        .LATENCY (LATENCY),
        .WW      (WW),
        .CW      (CW)
    ) u_resp_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (addr_ok_s),
        .pop         (data_ok_s),
        .cap_data    (ram_rdata),
        .full        (full_s),
        .empty       (empty_s),
        .cnt         (cnt_s),
        .head_ready  (head_ready_s),
        .head_dvalid (head_dvalid_s),
        .head_data   (head_data_s)
    );

    // Handshake, RAM read port and return data; a full queue may still accept
    // when its head leaves in the same cycle. Until the word is captured
    // (LATENCY=1), the return is bypassed straight from the RAM output.
    always_comb begin
        addr_ok_s  = 1'b0;
        data_ok_s  = 1'b0;
        rdata_s    = {INST_SRAM_DATA_W{1'b0}};
        ram_addr_s = {AW{1'b0}};
        if (reset) begin
            addr_ok_s  = 1'b0;
            data_ok_s  = 1'b0;
            rdata_s    = {INST_SRAM_DATA_W{1'b0}};
            ram_addr_s = {AW{1'b0}};
        end else begin
            data_ok_s = head_ready_s && !empty_s;
            if (inst_sram_req && !addr_hold && (!full_s || data_ok_s)) begin
                addr_ok_s = 1'b1;
            end else begin
                addr_ok_s = 1'b0;
            end
            if (addr_ok_s) begin
                ram_addr_s = inst_sram_addr[AW+1:2];
            end else begin
                ram_addr_s = {AW{1'b0}};
            end
            if (data_ok_s) begin
                rdata_s = head_dvalid_s ? head_data_s : ram_rdata;
            end else begin
                rdata_s = {INST_SRAM_DATA_W{1'b0}};
            end
        end
    end

    assign inst_sram_addr_ok = addr_ok_s;
    assign inst_sram_data_ok = data_ok_s;
    assign inst_sram_rdata   = rdata_s;
    assign ram_en            = addr_ok_s;
    assign ram_addr          = ram_addr_s;

    inst_sram_responder_chk #(
        .CW     (CW),
        .MAXCNT (OUTSTANDING)
    ) u_chk (
        .clk     (clk),
        .reset   (reset),
        .data_ok (data_ok_s),
        .rdata   (rdata_s),
        .cnt     (cnt_s)
    );

endmodule
